// File: rtl/rfphoenix_issue_sched_if.sv
// Issue-scheduler bundle: per-thread request/hazard inputs and the grant,
// issue, rollback-window and starvation outputs.
interface rfphoenix_issue_sched_if #(
  parameter int unsigned NTHREADS = 4
);
  localparam int unsigned TidW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

  logic [NTHREADS-1:0] req_v;
  logic [NTHREADS-1:0] can_issue;
  logic                ex_ready;
  logic                rollback;
  logic [TidW-1:0]     rollback_tid;
  logic [NTHREADS-1:0] will_issue;
  logic                issue_v;
  logic [TidW-1:0]     issue_tid;
  logic [NTHREADS-1:0] flush_mask;
  logic [NTHREADS-1:0] starved;

  modport master (
    output req_v, can_issue, ex_ready, rollback, rollback_tid,
    input  will_issue, issue_v, issue_tid, flush_mask, starved
  );

  modport slave (
    input  req_v, can_issue, ex_ready, rollback, rollback_tid,
    output will_issue, issue_v, issue_tid, flush_mask, starved
  );
endinterface

// File: rtl/rfphoenix_issue_sched.sv
// Single-slot issue arbiter for NTHREADS threads: starvation-priority then
// round-robin grant, with per-thread rollback flush windows.
module rfphoenix_issue_sched #(
  parameter int unsigned NTHREADS     = 4,
  parameter int unsigned FLUSH_CYCLES = 5,
  parameter int unsigned STARVE_LIM   = 15
) (
  input logic                    clk,
  input logic                    rst,
  rfphoenix_issue_sched_if.slave bus
);
  localparam int unsigned TidW   = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WaitW  = 4;

  typedef logic [TidW-1:0]   tid_t;
  typedef logic [FlushW-1:0] flush_cnt_t;
  typedef logic [WaitW-1:0]  wait_cnt_t;

  localparam tid_t       PtrRst    = tid_t'(NTHREADS - 1);
  localparam flush_cnt_t FlushLoad = flush_cnt_t'(FLUSH_CYCLES);
  localparam wait_cnt_t  StarveLim = wait_cnt_t'(STARVE_LIM);

  logic [NTHREADS-1:0] rb_hit, elig, starve_elig, grant;
  logic                found;
  tid_t                grant_tid, idx;

  tid_t                ptr_q, ptr_d;
  logic                issue_v_q, issue_v_d;
  tid_t                issue_tid_q, issue_tid_d;
  logic [NTHREADS-1:0] flush_mask_q, flush_mask_d;
  logic [NTHREADS-1:0] starved_q, starved_d;
  flush_cnt_t          flush_cnt_q [NTHREADS];
  flush_cnt_t          flush_cnt_d [NTHREADS];
  wait_cnt_t           wait_q      [NTHREADS];
  wait_cnt_t           wait_d      [NTHREADS];

  always_comb begin
    rb_hit = '0;
    if (bus.rollback) rb_hit[bus.rollback_tid] = 1'b1;
  end

  // Gating with rst keeps will_issue low while reset is held.
  assign elig = bus.req_v & bus.can_issue & ~flush_mask_q & ~rb_hit &
                {NTHREADS{bus.ex_ready & rst}};
  assign starve_elig = elig & starved_q;

  always_comb begin
    found     = 1'b0;
    grant_tid = ptr_q;
    idx       = ptr_q;
    grant     = '0;
    if (|starve_elig) begin
      for (int i = 0; i < NTHREADS; i++) begin
        if (starve_elig[i] && !found) begin
          found     = 1'b1;
          grant_tid = tid_t'(i);
        end
      end
    end else begin
      // Search starts just after the last granted thread and wraps.
      for (int k = 1; k <= NTHREADS; k++) begin
        idx = ptr_q + tid_t'(k);
        if (elig[idx] && !found) begin
          found     = 1'b1;
          grant_tid = idx;
        end
      end
    end
    if (found) grant[grant_tid] = 1'b1;
  end

  assign bus.will_issue = grant;

  always_comb begin
    ptr_d       = found ? grant_tid : ptr_q;
    issue_v_d   = found;
    issue_tid_d = found ? grant_tid : issue_tid_q;
    for (int i = 0; i < NTHREADS; i++) begin
      wait_d[i] = wait_q[i];
      if (grant[i] || !bus.req_v[i] || flush_mask_q[i]) begin
        wait_d[i] = '0;
      end else if (bus.can_issue[i] && (wait_q[i] < StarveLim)) begin
        wait_d[i] = wait_q[i] + wait_cnt_t'(1);
      end
      starved_d[i] = (wait_d[i] == StarveLim);

      // A rollback to an already-flushing thread restarts its window.
      flush_cnt_d[i] = flush_cnt_q[i];
      if (rb_hit[i]) begin
        flush_cnt_d[i] = FlushLoad;
      end else if (flush_cnt_q[i] != '0) begin
        flush_cnt_d[i] = flush_cnt_q[i] - flush_cnt_t'(1);
      end
      flush_mask_d[i] = (flush_cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q        <= PtrRst;
      issue_v_q    <= 1'b0;
      issue_tid_q  <= '0;
      flush_mask_q <= '0;
      starved_q    <= '0;
      flush_cnt_q  <= '{default: '0};
      wait_q       <= '{default: '0};
    end else begin
      ptr_q        <= ptr_d;
      issue_v_q    <= issue_v_d;
      issue_tid_q  <= issue_tid_d;
      flush_mask_q <= flush_mask_d;
      starved_q    <= starved_d;
      flush_cnt_q  <= flush_cnt_d;
      wait_q       <= wait_d;
    end
  end

  assign bus.issue_v    = issue_v_q;
  assign bus.issue_tid  = issue_tid_q;
  assign bus.flush_mask = flush_mask_q;
  assign bus.starved    = starved_q;

endmodule

// File: tb/tb_rfphoenix_issue_sched.sv
// Directed bench for rfphoenix_issue_sched: grant vectors checked inline,
// issued thread ids checked by a scoreboard monitor against expected queue.
module tb_rfphoenix_issue_sched;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_q[$];
  int   mon_exp;

  always #5 clk = ~clk;

  rfphoenix_issue_sched_if #(.NTHREADS(4)) bus ();

  rfphoenix_issue_sched #(
    .NTHREADS    (4),
    .FLUSH_CYCLES(5),
    .STARVE_LIM  (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drives one cycle, checks the grant, returns at the next falling edge.
  task automatic cyc(input logic [3:0] req, input logic [3:0] can, input logic exr,
                     input logic rb, input logic [1:0] rbtid, input logic [3:0] exp_will);
    bus.req_v        = req;
    bus.can_issue    = can;
    bus.ex_ready     = exr;
    bus.rollback     = rb;
    bus.rollback_tid = rbtid;
    #1;
    chk("will_issue", {28'd0, bus.will_issue}, {28'd0, exp_will});
    for (int i = 0; i < 4; i++) if (exp_will[i]) exp_q.push_back(i);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.issue_v === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_tid: unexpected issue of tid %0d, none required", bus.issue_tid);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.issue_tid !== 2'(mon_exp)) begin
          n_fail++;
          $display("FAIL issue_tid: got %0d, expected %0d (t=%0t)", bus.issue_tid, mon_exp,
                   $time);
        end
      end
    end
  end

  initial begin
    logic [3:0] c_exp [5];
    logic [3:0] d_exp [5];
    logic [3:0] e_exp [4];
    c_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    d_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    e_exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};

    rst              = 1'b0;
    bus.req_v        = 4'b1111;
    bus.can_issue    = 4'b1111;
    bus.ex_ready     = 1'b1;
    bus.rollback     = 1'b0;
    bus.rollback_tid = 2'd0;
    #1;
    chk("rst will_issue", {28'd0, bus.will_issue}, 32'd0);
    chk("rst issue_v", {31'd0, bus.issue_v}, 32'd0);
    chk("rst issue_tid", {30'd0, bus.issue_tid}, 32'd0);
    chk("rst flush_mask", {28'd0, bus.flush_mask}, 32'd0);
    chk("rst starved", {28'd0, bus.starved}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Plain round-robin from reset.
    for (int i = 0; i < 8; i++) cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0001 << (i % 4));
    cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0001);
    cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0010);

    // Rollback to thread 2 with ptr=1: grant skips to 3, thread 2 masked 5 cycles.
    cyc(4'hf, 4'hf, 1'b1, 1'b1, 2'd2, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      chk("flush_mask window", {28'd0, bus.flush_mask}, 32'b0100);
      cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, c_exp[i]);
    end
    chk("flush_mask cleared", {28'd0, bus.flush_mask}, 32'd0);
    cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0100);

    // Second rollback three cycles into the flush extends it to 8 cycles.
    cyc(4'hf, 4'hf, 1'b1, 1'b1, 2'd2, 4'b1000);
    chk("flush ext 1", {28'd0, bus.flush_mask}, 32'b0100);
    cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0001);
    chk("flush ext 2", {28'd0, bus.flush_mask}, 32'b0100);
    cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0010);
    chk("flush ext 3", {28'd0, bus.flush_mask}, 32'b0100);
    cyc(4'hf, 4'hf, 1'b1, 1'b1, 2'd2, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      chk("flush ext tail", {28'd0, bus.flush_mask}, 32'b0100);
      cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, d_exp[i]);
    end
    chk("flush ext cleared", {28'd0, bus.flush_mask}, 32'd0);
    cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0100);

    // ex_ready stall: no grants, issue_tid holds, order resumes from ptr=2.
    chk("pre-stall issue_v", {31'd0, bus.issue_v}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(4'hf, 4'hf, 1'b0, 1'b0, 2'd0, 4'b0000);
      chk("stall issue_v", {31'd0, bus.issue_v}, 32'd0);
      chk("stall issue_tid", {30'd0, bus.issue_tid}, 32'd2);
    end
    for (int i = 0; i < 4; i++) cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, e_exp[i]);

    // Starve thread 3: drop its request once, then hide can_issue[3] whenever it would win.
    cyc(4'b0111, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0001);
    for (int t = 0; t < 21; t++) begin
      case (t % 3)
        0:       cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0010);
        1:       cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0100);
        default: cyc(4'hf, 4'b0111, 1'b1, 1'b0, 2'd0, 4'b0001);
      endcase
    end
    chk("not yet starved", {28'd0, bus.starved}, 32'd0);
    // 15th counted loss for thread 3; also roll back thread 0 (thread 1 still granted).
    cyc(4'hf, 4'hf, 1'b1, 1'b1, 2'd0, 4'b0010);
    chk("starved set", {28'd0, bus.starved}, 32'b1000);
    chk("flush thread0", {28'd0, bus.flush_mask}, 32'b0001);
    bus.rollback = 1'b0;
    #1;
    chk("starve grant", {28'd0, bus.will_issue}, 32'b1000);

    // Asynchronous reset mid-flush and mid-starvation.
    #1 rst = 1'b0;
    #1;
    chk("async rst will_issue", {28'd0, bus.will_issue}, 32'd0);
    chk("async rst issue_v", {31'd0, bus.issue_v}, 32'd0);
    chk("async rst issue_tid", {30'd0, bus.issue_tid}, 32'd0);
    chk("async rst flush_mask", {28'd0, bus.flush_mask}, 32'd0);
    chk("async rst starved", {28'd0, bus.starved}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0001);
    cyc(4'hf, 4'hf, 1'b1, 1'b0, 2'd0, 4'b0010);
    #2;
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rfphoenix_issue_sched.md
RFPHOENIX_ISSUE_SCHED -- requirements
Module: rfPhoenix_issue_sched

Interface
REQ-001 Parameter NTHREADS, default 4: number of hardware threads competing for the single issue slot; power of two, 2..8.
REQ-002 Parameter FLUSH_CYCLES, default 5: cycles a thread is masked after a rollback; matches the scoreboard rollback depth.
REQ-003 Parameter STARVE_LIM, default 15: wait count at which a thread becomes starved; 4-bit counters.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_v  input  NTHREADS  per-thread decoded instruction valid.
REQ-007 can_issue  input  NTHREADS  per-thread scoreboard result; 1 = no source hazard.
REQ-008 ex_ready  input  1  execute stage accepts an instruction this cycle.
REQ-009 rollback  input  1  rollback request, single-cycle pulse.
REQ-010 rollback_tid  input  $clog2(NTHREADS)  thread being rolled back.
REQ-011 will_issue  output  NTHREADS  combinational one-hot-or-zero grant; drives each scoreboard's will_issue.
REQ-012 issue_v  output  1  registered: an instruction was issued last cycle.
REQ-013 issue_tid  output  $clog2(NTHREADS)  registered thread id of the last issue.
REQ-014 flush_mask  output  NTHREADS  registered: thread is in its rollback window.
REQ-015 starved  output  NTHREADS  registered: thread's wait counter has reached STARVE_LIM.

Function
REQ-016 elig[i] = req_v[i] & can_issue[i] & ~flush_mask[i] & ~(rollback & rollback_tid==i) & ex_ready.
REQ-017 will_issue shall be zero when no elig bit is set, and one-hot otherwise; never more than one bit.
REQ-018 Priority: if any elig thread has starved set, grant the lowest-index such thread; otherwise round-robin.
REQ-019 Round-robin: search starts at ptr+1 and wraps modulo NTHREADS; ptr is the last granted id.
REQ-020 ptr shall update to the granted id on every grant, including starvation grants; ptr holds when there is no grant.
REQ-021 issue_v <= |will_issue and issue_tid <= granted id; issue_tid holds its value when issue_v is 0. Latency is 1 cycle.
REQ-022 ex_ready low: all will_issue bits shall be 0 that cycle; ptr, issue_tid and the flush counters are unaffected.
REQ-023 Per-thread wait counter: increment (saturating at STARVE_LIM) when req_v & can_issue & ~flush_mask and the thread is not granted.
REQ-024 The wait counter shall clear on grant, when req_v is 0, or when the thread's flush_mask is set.
REQ-025 starved[i] <= (wait counter reaches STARVE_LIM).
REQ-026 Rollback: on rollback=1, the counter for rollback_tid loads FLUSH_CYCLES and flush_mask[rollback_tid] sets at the next edge.
REQ-027 The flush counter decrements each cycle while nonzero; flush_mask[i] = (counter != 0), so the mask is high for exactly FLUSH_CYCLES cycles.
REQ-028 A rollback to a thread that is already flushing shall reload its counter to FLUSH_CYCLES (extend, not stack).
REQ-029 A rollback in the same cycle as a would-be grant to the same thread shall suppress that grant. Other threads shall still be granted normally.
REQ-030 Rollback with an out-of-range rollback_tid (NTHREADS not power of two is illegal) is not required; all tid values are valid.

Reset
REQ-031 While rst=0: will_issue=0, issue_v=0, issue_tid=0, flush_mask=0, starved=0. All wait and flush counters are 0 and ptr=NTHREADS-1, so thread 0 wins first.
REQ-032 Reset asserted mid-flush or mid-starvation shall clear all state immediately. No grant shall occur in the first cycle after release unless elig is set.

Verification
REQ-033 Stimulus: after reset, req_v=1111, can_issue=1111, ex_ready=1 for 8 cycles. Response: will_issue sequence 0001,0010,0100,1000,0001,...; issue_tid lags by 1 cycle.
REQ-034 Stimulus: rollback=1, rollback_tid=2 while thread 2 is otherwise eligible and ptr=1. Response: will_issue=1000 that cycle; flush_mask=0100 for exactly 5 cycles; thread 2 is granted again only afterwards.
REQ-035 Stimulus: second rollback to thread 2 three cycles into its flush. Response: flush_mask[2] stays high 5 cycles past the second pulse (8 total).
REQ-036 Stimulus: ex_ready=0 for 4 cycles with all threads eligible. Response: will_issue=0 and issue_v=0 in each of those cycles; the grant order resumes from the same ptr.
REQ-037 Stimulus: can_issue[3] toggled so thread 3 repeatedly loses to threads 0-2 while eligible for 15 counted cycles. Response: starved[3]=1 and the next elig cycle grants 1000 ahead of round-robin; the counter then clears.
REQ-038 Stimulus: rst pulled low during an active flush and a starved state. Response: all outputs go to 0 asynchronously; after release, thread 0 is granted first.
